// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer. Rebuilds WIDTH-bit words from a strobed
// serial stream framed by a start pulse, and presents them through a one-entry
// valid/ready output register with a sticky overrun flag for dropped words.
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         serial_in,
  input  logic                         serial_valid,
  input  logic                         start,
  output logic [WIDTH-1:0]             par_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun,
  input  logic                         overrun_clr,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] par_q;
  logic [CntW-1:0]  cnt_q;
  logic             valid_q;
  logic             overrun_q;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;
  logic             take_start;
  logic             complete;
  logic             accept;
  logic             drop;

  // Next shift-register contents and word completion / handoff decisions.
  always_comb begin
    shifted = shift_q;
    first   = '0;
    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], serial_in};
      first   = {{(WIDTH-1){1'b0}}, serial_in};
    end else begin
      shifted = {serial_in, shift_q[WIDTH-1:1]};
      first   = {serial_in, {(WIDTH-1){1'b0}}};
    end
    take_start = serial_valid & start;
    // A start on the last bit is a resync, so it never completes a word.
    complete   = (state_q == StShift) & serial_valid & ~start & (cnt_q == LastCnt);
    // The output slot is free if empty or being drained on this same edge.
    accept     = ~valid_q | out_ready;
    drop       = complete & ~accept;
  end

  // Framing FSM, shift register, output register and overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      par_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (take_start) begin
            shift_q <= first;
            cnt_q   <= CntW'(1);
            state_q <= StShift;
          end
        end
        StShift: begin
          if (take_start) begin
            // Resync: drop the partial word, this bit becomes bit 0.
            shift_q <= first;
            cnt_q   <= CntW'(1);
          end else if (serial_valid) begin
            shift_q <= shifted;
            if (cnt_q == LastCnt) begin
              cnt_q   <= '0;
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (complete && accept) begin
        par_q   <= shifted;
        valid_q <= 1'b1;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end

      // Set has priority over a coincident clear.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign par_out   = par_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == StShift);
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: two instances (MSB-first and LSB-first)
// share one stimulus stream, and each step is checked against hand-computed values.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       serial_valid;
  logic       start;
  logic       out_ready;
  logic       overrun_clr;

  logic [3:0] m_par, l_par;
  logic       m_valid, l_valid;
  logic       m_ovr, l_ovr;
  logic       m_busy, l_busy;
  logic [2:0] m_cnt, l_cnt;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .start        (start),
    .par_out      (m_par),
    .out_valid    (m_valid),
    .out_ready    (out_ready),
    .overrun      (m_ovr),
    .overrun_clr  (overrun_clr),
    .busy         (m_busy),
    .bit_cnt      (m_cnt)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .start        (start),
    .par_out      (l_par),
    .out_valid    (l_valid),
    .out_ready    (out_ready),
    .overrun      (l_ovr),
    .overrun_clr  (overrun_clr),
    .busy         (l_busy),
    .bit_cnt      (l_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic st, input logic b);
    serial_valid = 1'b1;
    start        = st;
    serial_in    = b;
    tick();
    serial_valid = 1'b0;
    start        = 1'b0;
    serial_in    = 1'b0;
  endtask

  // Sends w[3] first, with start on that first bit.
  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_bit(i == 3, w[i]);
    end
  endtask

  initial begin
    rst          = 1'b1;
    serial_in    = 1'b0;
    serial_valid = 1'b0;
    start        = 1'b0;
    out_ready    = 1'b0;
    overrun_clr  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_par", m_par, 4'b0000);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_ovr", m_ovr, 1'b0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_cnt", m_cnt, 3'd0);

    // Basic word 1,0,1,1 with consumer ready
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    chk("basic_cnt1", m_cnt, 3'd1);
    chk("basic_busy1", m_busy, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("basic_cnt2", m_cnt, 3'd2);
    send_bit(1'b0, 1'b1);
    chk("basic_cnt3", m_cnt, 3'd3);
    chk("basic_busy3", m_busy, 1'b1);
    send_bit(1'b0, 1'b1);
    chk("basic_cnt0", m_cnt, 3'd0);
    chk("basic_busy0", m_busy, 1'b0);
    chk("basic_valid", m_valid, 1'b1);
    chk("basic_par_msb", m_par, 4'b1011);
    chk("basic_par_lsb", l_par, 4'b1101);
    tick();
    chk("basic_valid_drop", m_valid, 1'b0);

    // Idle noise: bits without start are ignored
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    chk("noise_cnt", m_cnt, 3'd0);
    chk("noise_busy", m_busy, 1'b0);
    chk("noise_valid", m_valid, 1'b0);

    // Gap of three idle cycles mid-word
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    repeat (3) tick();
    chk("gap_cnt", m_cnt, 3'd2);
    chk("gap_busy", m_busy, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    chk("gap_par_msb", m_par, 4'b1011);
    chk("gap_par_lsb", l_par, 4'b1101);
    chk("gap_valid", m_valid, 1'b1);
    tick();

    // Back-pressure: second word is dropped and flags overrun
    out_ready = 1'b0;
    send_word(4'b1011);
    chk("bp_valid1", m_valid, 1'b1);
    chk("bp_ovr0", m_ovr, 1'b0);
    send_word(4'b0110);
    chk("bp_par_msb", m_par, 4'b1011);
    chk("bp_par_lsb", l_par, 4'b1101);
    chk("bp_ovr1", m_ovr, 1'b1);
    chk("bp_ovr1_lsb", l_ovr, 1'b1);
    chk("bp_valid_held", m_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drain", m_valid, 1'b0);
    chk("bp_ovr_sticky", m_ovr, 1'b1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("bp_ovr_clr", m_ovr, 1'b0);

    // Resync after two bits, then 1,1,0,0
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("rs_cnt2", m_cnt, 3'd2);
    send_bit(1'b1, 1'b1);
    chk("rs_cnt1", m_cnt, 3'd1);
    chk("rs_busy", m_busy, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("rs_par_msb", m_par, 4'b1100);
    chk("rs_par_lsb", l_par, 4'b0011);
    chk("rs_ovr", m_ovr, 1'b0);
    chk("rs_valid", m_valid, 1'b1);
    tick();

    // Completion on the same edge a held word is accepted
    out_ready = 1'b0;
    send_word(4'b1010);
    chk("sim_par_a", m_par, 4'b1010);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b1);
    chk("sim_valid", m_valid, 1'b1);
    chk("sim_par_msb", m_par, 4'b0101);
    chk("sim_par_lsb", l_par, 4'b1010);
    chk("sim_ovr", m_ovr, 1'b0);
    tick();
    chk("sim_valid_drop", m_valid, 1'b0);

    // Asynchronous reset mid-word with a held output word
    out_ready = 1'b0;
    send_word(4'b1011);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("ar_pre_cnt", m_cnt, 3'd2);
    chk("ar_pre_valid", m_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_par", m_par, 4'b0000);
    chk("ar_valid", m_valid, 1'b0);
    chk("ar_ovr", m_ovr, 1'b0);
    chk("ar_busy", m_busy, 1'b0);
    chk("ar_cnt", m_cnt, 3'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    send_word(4'b0110);
    chk("ar_post_par_msb", m_par, 4'b0110);
    chk("ar_post_par_lsb", l_par, 4'b0110);
    chk("ar_post_valid", m_valid, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
